// File: rtl/fifo_word_serializer.sv
// -----------------------------------------------------------------------------
// fifo_word_serializer
//
// Pops WIDTH-bit words from an upstream FIFO with a one-cycle read latency and
// sends each word as RATIO = WIDTH/OUT_WIDTH beats on a valid/ready stream.
// WIDTH must be a multiple of OUT_WIDTH, and RATIO must be at least 2.
//
// Ports:
//   clock       rising-edge clock
//   aresetn     asynchronous active-low reset
//   fifo_empty  upstream FIFO empty flag
//   fifo_rd_en  pop strobe to the FIFO (combinational, never asserted on empty)
//   fifo_data   FIFO read data, valid the cycle after fifo_rd_en
//   m_valid     output beat valid (registered)
//   m_ready     downstream accepts the beat
//   m_data      output beat (registered)
//   m_last      final beat of a word (registered)
//   busy        high while a word is being fetched or sent
//   word_count  number of words fully sent, wraps modulo 2^CNT_WIDTH
// -----------------------------------------------------------------------------
module fifo_word_serializer #(
  parameter int WIDTH     = 32,
  parameter int OUT_WIDTH = 8,
  parameter int MSB_FIRST = 0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 aresetn,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic [WIDTH-1:0]     fifo_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic                 m_last,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] word_count
);

  localparam int RATIO = WIDTH / OUT_WIDTH;
  localparam int BCW   = (RATIO > 2) ? $clog2(RATIO) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(RATIO - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] SEND  = 2'd2;

  logic [1:0]       state;
  logic [BCW-1:0]   beat_cnt;
  logic [BCW-1:0]   beat_cnt_next;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic             xfer;
  logic             last_xfer;

  // The beat on the wire is always the "front" of the shift register; after
  // each transfer the register moves one beat toward that front.
  function automatic logic [OUT_WIDTH-1:0] front_beat(input logic [WIDTH-1:0] w);
    if (MSB_FIRST != 0) return w[WIDTH-1 -: OUT_WIDTH];
    else                return w[OUT_WIDTH-1:0];
  endfunction

  assign shift_next    = (MSB_FIRST != 0) ? (shift_reg << OUT_WIDTH)
                                          : (shift_reg >> OUT_WIDTH);
  assign beat_cnt_next = beat_cnt + 1'b1;
  assign xfer          = m_valid & m_ready;
  assign last_xfer     = (state == SEND) && xfer && (beat_cnt == LAST_BEAT);
  assign busy          = (state != IDLE);

  // Pop in IDLE, or on the last-beat transfer so the next word lands during
  // the following FETCH cycle. Reset gates it so a held-in-reset block never
  // pops, even with a non-empty FIFO.
  always_comb begin
    // NOTE: assign a default first so every path drives the signal; a missing
    // branch would otherwise infer a latch.
    fifo_rd_en = 1'b0;
    if (aresetn && !fifo_empty) begin
      if (state == IDLE || last_xfer) fifo_rd_en = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_last     <= 1'b0;
      word_count <= '0;
      beat_cnt   <= '0;
      // NOTE: the shift register is plain flops, not a RAM, so clearing it on
      // reset is cheap and keeps a discarded word from lingering.
      shift_reg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_rd_en) state <= FETCH;
        end

        FETCH: begin
          shift_reg <= fifo_data;
          beat_cnt  <= '0;
          m_data    <= front_beat(fifo_data);
          m_valid   <= 1'b1;
          m_last    <= 1'b0;
          state     <= SEND;
        end

        SEND: begin
          if (xfer) begin
            if (beat_cnt != LAST_BEAT) begin
              shift_reg <= shift_next;
              m_data    <= front_beat(shift_next);
              beat_cnt  <= beat_cnt_next;
              m_last    <= (beat_cnt_next == LAST_BEAT);
            end else begin
              // Word complete: fifo_rd_en already popped the next word this
              // cycle if one was available.
              word_count <= word_count + 1'b1;
              m_valid    <= 1'b0;
              m_last     <= 1'b0;
              state      <= fifo_empty ? IDLE : FETCH;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fifo_word_serializer.md
Name: fifo_word_serializer

Overview:
- Drains WIDTH-bit words from the upstream word FIFO and emits each word as WIDTH/OUT_WIDTH narrower beats on a valid/ready stream.
- Sits directly downstream of the FIFO: it drives the FIFO read strobe, watches its empty flag, and captures its read data.
- Provides byte-stream output for serial/peripheral stages.

Parameters:
- WIDTH, 32: FIFO word width. Must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 8: output beat width. RATIO = WIDTH/OUT_WIDTH, and RATIO must be >= 2.
- MSB_FIRST, 0: 0 sends bits [OUT_WIDTH-1:0] first; 1 sends the top OUT_WIDTH bits first.
- CNT_WIDTH, 16: width of the word counter.

Ports:
- clock, input, 1: rising-edge clock.
- aresetn, input, 1: asynchronous active-low reset.
- fifo_empty, input, 1: upstream FIFO empty flag.
- fifo_rd_en, output, 1: pop request to the FIFO.
- fifo_data, input, WIDTH: FIFO read data, valid the cycle after fifo_rd_en.
- m_valid, output, 1: output beat valid.
- m_ready, input, 1: downstream accepts the beat.
- m_data, output, OUT_WIDTH: output beat.
- m_last, output, 1: marks the final beat of a word.
- busy, output, 1: high in any state other than IDLE.
- word_count, output, CNT_WIDTH: number of words fully sent. Wraps modulo 2^CNT_WIDTH.

Behaviour:
- Single clock domain: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, m_valid=0, m_data=0, m_last=0, word_count=0, beat counter=0, shift register=0.
- fifo_rd_en is combinational and forced to 0 while aresetn=0.
- Handshake: a beat transfers on a rising edge with m_valid=1 and m_ready=1.
  - m_valid, m_data and m_last are registered.
  - They are held stable while m_valid=1 and m_ready=0.
  - m_valid never drops without a transfer, except on reset.
- FIFO read latency is 1: a pop at edge N presents the word on fifo_data during cycle N+1, captured at edge N+1.
- fifo_rd_en is asserted only when fifo_empty=0, so there is never a pop on empty.
- State machine:
  - IDLE: fifo_rd_en = !fifo_empty. If it is asserted, go to FETCH.
  - FETCH: capture fifo_data into the shift register and clear the beat counter. Load m_data with the first beat, set m_valid=1, and set m_last=0. Go to SEND.
  - SEND, on a transfer with beat counter < RATIO-1: shift to the next beat and increment the beat counter. Set m_last=1 when the new beat index equals RATIO-1.
  - SEND, on a transfer with beat counter = RATIO-1 (m_last=1): increment word_count. Then:
    - If fifo_empty=0 in that same cycle: fifo_rd_en=1 combinationally, m_valid<=0, go to FETCH.
    - Otherwise: m_valid<=0, m_last<=0, go to IDLE.
  - fifo_rd_en=0 in SEND except on the last-beat transfer cycle.
- Throughput: with FIFO non-empty and m_ready held at 1, one word per RATIO+1 cycles. The single-cycle bubble is the FETCH cycle.
- Beat order:
  - MSB_FIRST=0: beat k = word[k*OUT_WIDTH +: OUT_WIDTH].
  - MSB_FIRST=1: beat k = word[WIDTH-1-k*OUT_WIDTH -: OUT_WIDTH].
- Backpressure: m_ready may toggle arbitrarily, and beats are never lost or duplicated.
- fifo_empty transitions during SEND are ignored, except on the last-beat transfer cycle.
- word_count wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- Reset mid-word: the partial word is discarded. All outputs return to reset values immediately (asynchronously). No pop occurs on the first edge after deassertion unless fifo_empty=0 in IDLE.
- busy=1 in FETCH and SEND.

Test Plan:
- Reset: hold aresetn=0 with fifo_empty=0 -> fifo_rd_en=0, m_valid=0, m_data=0, word_count=0. Release -> fifo_rd_en=1 in the first IDLE cycle.
- Single word, MSB_FIRST=0, fifo_data=32'hA1B2C3D4, m_ready=1:
  - Beats are D4, C3, B2, A1 on consecutive cycles, with m_last only on A1.
  - word_count=1, then IDLE with busy=0.
- MSB_FIRST=1, same word -> beats A1, B2, C3, D4, with m_last on D4.
- Backpressure: m_ready=0 for 3 cycles while beat C3 is presented -> m_data holds C3 with m_valid=1, then resumes B2, A1. Exactly 4 transfers occur.
- Back-to-back: 3 words queued (11223344, 55667788, 99AABBCC), m_ready=1:
  - 12 beats in order; fifo_rd_en pulses on the cycle of each last-beat transfer.
  - Total 15 cycles from the first FETCH to the final transfer; word_count=3.
- Reset mid-word: assert aresetn=0 after beat 2 of 32'hDEADBEEF -> m_valid=0 at once and word_count=0. The next word starts at beat 0.
